// File: rtl/gpio_input_port_pkg.sv
// Shared constants for the GPIO input port: bus width and register offsets
// relative to the port's base address.
package gpio_input_port_pkg;

   localparam int BUS_W = 32;

   localparam logic [BUS_W-1:0] GPIO_IN_DATA_OFS = 32'h0000_0000;
   localparam logic [BUS_W-1:0] GPIO_IN_FLAG_OFS = 32'h0000_0004;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One input pin: 2-FF synchronizer, debounce counter and filtered bit, plus a
// strobe that fires on the same edge the filtered bit rises.
module gpio_debounce_bit #(
   parameter int DEBOUNCE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_pin,
   output logic o_filtered,
   output logic o_rise
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             r_s1;
   logic             r_s2;
   logic             r_filtered;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differs;
   logic             w_settle;

   assign w_differs  = (r_s2 != r_filtered);
   assign w_settle   = w_differs && (r_cnt == CNT_LAST);
   assign o_filtered = r_filtered;
   assign o_rise     = w_settle && r_s2;

   // The counter only advances while the synchronized pin disagrees with the
   // filtered value, so any agreement in between restarts the qualification.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_filtered <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_s1 <= i_pin;
         r_s2 <= r_s1;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_settle) begin
            r_filtered <= r_s2;
            r_cnt      <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: debounced pin state and sticky rising-edge
// flags, readable at base and base+4; flags clear on read and drive irq.
module gpio_input_port
   import gpio_input_port_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int DEBOUNCE = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_in,
   input  logic [BUS_W-1:0] port_addr,
   input  logic [BUS_W-1:0] rd_addr,
   input  logic             rd_en,
   output logic [BUS_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             irq
);

   logic [WIDTH-1:0] w_filtered;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_clrMask;
   logic [WIDTH-1:0] w_flagsNext;
   logic [BUS_W-1:0] w_filtExt;
   logic [BUS_W-1:0] w_flagExt;
   logic             w_dataHit;
   logic             w_flagHit;

   logic [WIDTH-1:0] r_flags;
   logic [BUS_W-1:0] r_rdData;
   logic             r_rdValid;
   logic             r_irq;

   for (genvar g = 0; g < WIDTH; g++) begin : g_pin
      gpio_debounce_bit #(
         .DEBOUNCE (DEBOUNCE)
      ) u_bit (
         .clock      (clock),
         .reset      (reset),
         .i_pin      (pins_in[g]),
         .o_filtered (w_filtered[g]),
         .o_rise     (w_rise[g])
      );
   end

   // A flag read clears exactly the bits it returns; a rise on the same edge
   // is OR-ed back in afterwards so a new event is never lost.
   always_comb begin
      w_filtExt               = '0;
      w_flagExt               = '0;
      w_filtExt[WIDTH-1:0]    = w_filtered;
      w_flagExt[WIDTH-1:0]    = r_flags;
      w_dataHit               = rd_en && (rd_addr == port_addr + GPIO_IN_DATA_OFS);
      w_flagHit               = rd_en && (rd_addr == port_addr + GPIO_IN_FLAG_OFS);
      w_clrMask               = w_flagHit ? r_flags : '0;
      w_flagsNext             = (r_flags & ~w_clrMask) | w_rise;
   end

   // irq is taken from the next flag value so it tracks the flag register
   // edge-for-edge instead of lagging it by a cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_flags   <= '0;
         r_rdData  <= '0;
         r_rdValid <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_flags   <= w_flagsNext;
         r_irq     <= |w_flagsNext;
         r_rdValid <= w_dataHit || w_flagHit;
         if (w_dataHit) begin
            r_rdData <= w_filtExt;
         end else if (w_flagHit) begin
            r_rdData <= w_flagExt;
         end
      end
   end

   assign rd_data  = r_rdData;
   assign rd_valid = r_rdValid;
   assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_input_port.sv
// Directed bench for gpio_input_port: reset-time edges, debounce, address
// decode, clear-on-read, set-wins-over-clear and falling edges.
module tb_gpio_input_port;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pins_in;
   logic [31:0] port_addr;
   logic [31:0] rd_addr;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        irq;

   int checks = 0;
   int errors = 0;

   gpio_input_port #(
      .WIDTH    (32),
      .DEBOUNCE (4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .pins_in   (pins_in),
      .port_addr (port_addr),
      .rd_addr   (rd_addr),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .irq       (irq)
   );

   always #5 clock = ~clock;

   // Advance n rising edges; outputs are then sampled 1 time unit later.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One-cycle read strobe; results are valid right after the returned tick.
   task automatic applyStimulus(input logic [31:0] addr);
      rd_en   = 1'b1;
      rd_addr = addr;
      tick(1);
      rd_en   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      port_addr = 32'h0000_0100;
      rd_addr   = 32'h0;
      rd_en     = 1'b0;
      pins_in   = 32'hFFFF_FFFF;
      reset     = 1'b1;
      tick(3);
      reset = 1'b0;
      checkOutput("reset rd_data", rd_data, 32'h0);
      checkOutput("reset rd_valid", {31'b0, rd_valid}, 32'h0);
      checkOutput("reset irq", {31'b0, irq}, 32'h0);

      tick(5);
      checkOutput("boot irq edge5", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("boot irq edge6", {31'b0, irq}, 32'h1);
      applyStimulus(32'h100);
      checkOutput("boot filtered", rd_data, 32'hFFFF_FFFF);
      checkOutput("boot data valid", {31'b0, rd_valid}, 32'h1);
      applyStimulus(32'h104);
      checkOutput("boot flags", rd_data, 32'hFFFF_FFFF);
      checkOutput("boot irq cleared", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("valid drops", {31'b0, rd_valid}, 32'h0);
      checkOutput("data held idle", rd_data, 32'hFFFF_FFFF);

      pins_in = 32'h0;
      tick(6);
      applyStimulus(32'h100);
      checkOutput("all fall filtered", rd_data, 32'h0);
      applyStimulus(32'h104);
      checkOutput("all fall no flags", rd_data, 32'h0);

      pins_in = 32'h8;
      tick(3);
      pins_in = 32'h0;
      tick(8);
      checkOutput("glitch no irq", {31'b0, irq}, 32'h0);
      applyStimulus(32'h100);
      checkOutput("glitch filtered", rd_data, 32'h0);
      applyStimulus(32'h104);
      checkOutput("glitch flags", rd_data, 32'h0);

      pins_in = 32'h8;
      tick(5);
      checkOutput("pulse4 irq edge5", {31'b0, irq}, 32'h0);
      tick(1);
      checkOutput("pulse4 irq edge6", {31'b0, irq}, 32'h1);
      applyStimulus(32'h100);
      checkOutput("pulse4 filtered", rd_data, 32'h8);
      applyStimulus(32'h104);
      checkOutput("pulse4 flags", rd_data, 32'h8);
      applyStimulus(32'h200);
      checkOutput("miss valid", {31'b0, rd_valid}, 32'h0);
      checkOutput("miss data held", rd_data, 32'h8);

      pins_in = 32'hD;
      tick(6);
      checkOutput("flags5 irq", {31'b0, irq}, 32'h1);
      applyStimulus(32'h104);
      checkOutput("flags5 read", rd_data, 32'h5);
      checkOutput("flags5 irq drop", {31'b0, irq}, 32'h0);
      applyStimulus(32'h104);
      checkOutput("flags5 reread", rd_data, 32'h0);
      checkOutput("flags5 reread valid", {31'b0, rd_valid}, 32'h1);

      pins_in = 32'h8;
      tick(6);
      pins_in = 32'hA;
      tick(6);
      pins_in = 32'hB;
      tick(5);
      applyStimulus(32'h104);
      checkOutput("setwins read", rd_data, 32'h2);
      checkOutput("setwins irq", {31'b0, irq}, 32'h1);
      applyStimulus(32'h104);
      checkOutput("setwins reread", rd_data, 32'h1);
      checkOutput("setwins irq drop", {31'b0, irq}, 32'h0);

      pins_in = 32'hA;
      tick(6);
      applyStimulus(32'h100);
      checkOutput("fall filtered", rd_data, 32'hA);
      applyStimulus(32'h104);
      checkOutput("fall no flag", rd_data, 32'h0);
      checkOutput("fall irq", {31'b0, irq}, 32'h0);

      pins_in = 32'h1;
      tick(3);
      reset = 1'b1;
      tick(1);
      reset   = 1'b0;
      pins_in = 32'h0;
      tick(10);
      applyStimulus(32'h100);
      checkOutput("reset midway filtered", rd_data, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
